mem_loader: RTL
===============

Name: mem_loader

Overview:
- Host-side initiator for the cpu's external memory-access ports (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext and the _2 set).
- Streams a program into instruction memory and an initial image into data memory, then asserts cpu enable for a programmed number of cycles.
- Afterwards reads back the data-memory region and streams it out.
- Sits between the testbench/host link and the cpu top.

Parameters:
- IMEM_WORDS, 512, words written to instruction memory per load (>=1).
- DMEM_WORDS, 1024, words written to data memory per load and read back in dump (>=1).
- ADDR_STEP, 4, byte-address increment per word; word index k maps to address k*ADDR_STEP.
- CNT_W, 11, width of word counter (must hold max(IMEM_WORDS,DMEM_WORDS)).

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load/run/dump sequence (sampled only in IDLE)
- run_cycles  in  32  cycles of cpu enable; sampled on accepted start
- in_valid  in  1  load stream word valid
- in_ready  out  1  load stream ready
- in_data  in  32  load stream word (IMEM words first, then DMEM words)
- out_valid  out  1  dump stream valid
- out_ready  in  1  dump stream ready
- out_data  out  32  dump stream word
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the last dump word is accepted
- cpu_enable  out  1  to cpu enable
- imem_addr  out  32  to addr_ext
- imem_wen  out  1  to wen_ext
- imem_ren  out  1  to ren_ext (tied 0)
- imem_wdata  out  32  to wdata_ext
- dmem_addr  out  32  to addr_ext_2
- dmem_wen  out  1  to wen_ext_2
- dmem_ren  out  1  to ren_ext_2
- dmem_wdata  out  32  to wdata_ext_2
- dmem_rdata  in  32  from rdata_ext_2

Behaviour:
- Reset (async, arst_n=0):
  - state=IDLE; all outputs 0 (out_data=0, addresses=0, cpu_enable=0).
  - Counters cleared. Reset mid-sequence aborts immediately; cpu_enable drops asynchronously.
- FSM states: IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WT, DUMP_OUT.
- All memory-side outputs are registered.
- IDLE:
  - start=1 -> LOAD_I; latch run_cycles; word counter k=0.
  - start in any other state is ignored.
- LOAD_I:
  - in_ready=1.
  - On in_valid&in_ready, the next cycle drives imem_wen=1 for exactly 1 cycle, with imem_addr=k*ADDR_STEP and imem_wdata=in_data. k increments.
  - When handshake k==IMEM_WORDS-1 -> LOAD_D with k=0.
  - in_valid=0 stalls indefinitely; wen stays 0.
- LOAD_D:
  - Same as LOAD_I on the dmem_* ports with DMEM_WORDS.
  - After the last handshake, the final dmem write still issues in the following cycle. in_ready=0 from that cycle.
  - Next state is RUN, or DUMP_RD if the latched run_cycles==0.
- RUN:
  - cpu_enable=1 for exactly run_cycles consecutive cycles, using a down-counter.
  - The cycle after the counter reaches 0: cpu_enable=0, state -> DUMP_RD, k=0.
  - No ext memory access during RUN (all wen/ren=0).
- DUMP_RD: dmem_ren=1 for 1 cycle, dmem_addr=k*ADDR_STEP -> DUMP_WT.
- DUMP_WT:
  - Memory read latency is 1 cycle.
  - Capture dmem_rdata into out_data; out_valid=1 -> DUMP_OUT.
- DUMP_OUT:
  - Hold out_valid/out_data stable until out_ready.
  - On handshake: out_valid=0 next cycle, k++. Go to DUMP_RD, or if k was DMEM_WORDS-1, assert done for 1 cycle and go to IDLE.
- Throughput:
  - Load: 1 word/cycle.
  - Dump: 3 cycles/word minimum with out_ready tied high.
- Counters never wrap: the end-of-phase compare occurs at COUNT-1.
- run_cycles arithmetic: 32-bit unsigned; 0xFFFFFFFF is legal.
- Invariants: imem_wen and dmem_wen are never both 1; no wen/ren active while cpu_enable=1.

Decomposition:
- Shared package: state encoding enum for the FSM states; ADDR_STEP default; cycle-count width constant (32).
- One natural sub-module: word_addr_gen, a counter with clear/increment/last-flag that outputs k*ADDR_STEP. It is instantiated once and shared across phases.

Test Plan:
1. IMEM_WORDS=4, DMEM_WORDS=2, in_valid always 1, in_data=1..6:
   - imem writes 1,2,3,4 at addresses 0,4,8,12 on consecutive cycles.
   - dmem writes 5,6 at addresses 0,4.
2. Same sequence with in_valid toggling 1/0 each cycle -> identical write contents; one write per handshake; no extra wen pulses.
3. run_cycles=10 -> cpu_enable high for exactly 10 cycles; then the first dmem_ren occurs at address 0.
4. run_cycles=0 -> cpu_enable never asserted; dump starts directly after the last dmem write.
5. Dump with a memory model returning 0xA5A5_0000+addr and out_ready held low 5 cycles per word:
   - out_data stays stable while stalled; words arrive in order.
   - done pulses once, then busy=0.
6. Assert arst_n=0 during RUN, then start again -> cpu_enable=0 immediately; full sequence repeats correctly from k=0.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the mem_loader block.
//   state_e            : sequencer state encoding
//   ADDR_STEP_DEFAULT  : default byte increment per memory word
//   CYC_W              : width of the run-cycle counter
//   WORD_W             : width of one memory / stream word
package mem_loader_pkg;

    localparam int unsigned ADDR_STEP_DEFAULT = 4;
    localparam int unsigned CYC_W             = 32;
    localparam int unsigned WORD_W            = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_WT,
        S_DUMP_OUT
    } state_e;

endpackage

// File: rtl/mem_loader_if.sv
// Bus bundle between mem_loader and its surroundings: the host load stream,
// the host dump stream and the two cpu external memory-access ports.
//   master : the loader side (drives ready/valid outputs and memory requests)
//   slave  : the host link plus memory side
interface mem_loader_if;
    import mem_loader_pkg::*;

    // host load stream
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    // host dump stream
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    // instruction memory port (addr_ext / wen_ext / ren_ext / wdata_ext)
    logic [31:0]       imem_addr;
    logic              imem_wen;
    logic              imem_ren;
    logic [WORD_W-1:0] imem_wdata;
    // data memory port (*_ext_2)
    logic [31:0]       dmem_addr;
    logic              dmem_wen;
    logic              dmem_ren;
    logic [WORD_W-1:0] dmem_wdata;
    logic [WORD_W-1:0] dmem_rdata;

    modport master (
        input  in_valid, in_data, out_ready, dmem_rdata,
        output in_ready, out_valid, out_data,
               imem_addr, imem_wen, imem_ren, imem_wdata,
               dmem_addr, dmem_wen, dmem_ren, dmem_wdata
    );

    modport slave (
        output in_valid, in_data, out_ready, dmem_rdata,
        input  in_ready, out_valid, out_data,
               imem_addr, imem_wen, imem_ren, imem_wdata,
               dmem_addr, dmem_wen, dmem_ren, dmem_wdata
    );

endinterface

// File: rtl/word_addr_gen.sv
// Word counter shared by every phase of mem_loader.
//   clr       : return to word 0 (wins over inc)
//   inc       : advance one word
//   last_idx  : index of the final word of the current phase
//   addr      : k * ADDR_STEP for the current word k
//   next_addr : address of word k+1
//   is_last   : k == last_idx
// The address is kept as its own accumulator so no multiplier is needed.
module word_addr_gen
    import mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_STEP = ADDR_STEP_DEFAULT,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] last_idx,
    output logic [31:0]      addr,
    output logic [31:0]      next_addr,
    output logic             is_last
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned, which would infer a latch.
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (clr) begin
            cnt_d  = '0;
            addr_d = '0;
        end else if (inc) begin
            cnt_d  = cnt_q + CNT_W'(1);
            addr_d = addr_q + STEP;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        // NOTE: non-blocking assignments here so all flops update together from pre-edge values.
        if (!arst_n) begin
            cnt_q  <= '0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    assign addr      = addr_q;
    assign next_addr = addr_q + STEP;
    assign is_last   = (cnt_q == last_idx);

endmodule

// File: rtl/mem_loader.sv
// Host-side initiator for the cpu external memory ports.
// Sequence: load IMEM_WORDS words into instruction memory, DMEM_WORDS words
// into data memory, enable the cpu for run_cycles cycles, then read the data
// memory region back and stream it out.
//   clk, arst_n : clock, asynchronous active-low reset
//   start       : begin a sequence (only honoured in IDLE)
//   run_cycles  : cpu enable duration, latched on accepted start
//   busy        : sequence in progress
//   done        : one-cycle pulse after the final dump word is accepted
//   cpu_enable  : cpu enable
//   bus         : load/dump streams and both memory ports (master view)
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 1024,
    parameter int unsigned ADDR_STEP  = ADDR_STEP_DEFAULT,
    parameter int unsigned CNT_W      = 11
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CYC_W-1:0] run_cycles,
    output logic             busy,
    output logic             done,
    output logic             cpu_enable,
    mem_loader_if.master     bus
);

    localparam logic [CNT_W-1:0] IMEM_LAST = CNT_W'(IMEM_WORDS - 1);
    localparam logic [CNT_W-1:0] DMEM_LAST = CNT_W'(DMEM_WORDS - 1);

    state_e            state_q, state_d;
    logic [CYC_W-1:0]  run_cnt_q, run_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [31:0]       imem_addr_q, imem_addr_d;
    logic              imem_wen_q, imem_wen_d;
    logic [WORD_W-1:0] imem_wdata_q, imem_wdata_d;
    logic [31:0]       dmem_addr_q, dmem_addr_d;
    logic              dmem_wen_q, dmem_wen_d;
    logic              dmem_ren_q, dmem_ren_d;
    logic [WORD_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cpu_en_q, cpu_en_d;

    logic              k_clr, k_inc, k_is_last;
    logic [CNT_W-1:0]  k_last_idx;
    logic [31:0]       k_addr, k_next_addr;
    logic              in_hs;

    assign k_last_idx = (state_q == S_LOAD_I) ? IMEM_LAST : DMEM_LAST;
    assign in_hs      = bus.in_valid & in_ready_q;

    word_addr_gen #(
        .ADDR_STEP (ADDR_STEP),
        .CNT_W     (CNT_W)
    ) u_word_addr_gen (
        .clk       (clk),
        .arst_n    (arst_n),
        .clr       (k_clr),
        .inc       (k_inc),
        .last_idx  (k_last_idx),
        .addr      (k_addr),
        .next_addr (k_next_addr),
        .is_last   (k_is_last)
    );

    always_comb begin
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        imem_addr_d  = imem_addr_q;
        imem_wen_d   = 1'b0;
        imem_wdata_d = imem_wdata_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wen_d   = 1'b0;
        dmem_ren_d   = dmem_ren_q;
        dmem_wdata_d = dmem_wdata_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cpu_en_d     = cpu_en_q;
        k_clr        = 1'b0;
        k_inc        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD_I;
                    run_cnt_d  = run_cycles;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    k_clr      = 1'b1;
                end
            end

            S_LOAD_I: begin
                if (in_hs) begin
                    imem_wen_d   = 1'b1;
                    imem_addr_d  = k_addr;
                    imem_wdata_d = bus.in_data;
                    if (k_is_last) begin
                        k_clr   = 1'b1;
                        state_d = S_LOAD_D;
                    end else begin
                        k_inc   = 1'b1;
                    end
                end
            end

            S_LOAD_D: begin
                if (in_hs) begin
                    dmem_wen_d   = 1'b1;
                    dmem_addr_d  = k_addr;
                    dmem_wdata_d = bus.in_data;
                    if (k_is_last) begin
                        k_clr      = 1'b1;
                        in_ready_d = 1'b0;
                        state_d    = (run_cnt_q == '0) ? S_DUMP_RD : S_RUN;
                    end else begin
                        k_inc      = 1'b1;
                    end
                end
            end

            S_RUN: begin
                // The final dmem write is on the bus during the first RUN
                // cycle, so enable only rises one cycle later.
                if (run_cnt_q != '0) begin
                    cpu_en_d  = 1'b1;
                    run_cnt_d = run_cnt_q - CYC_W'(1);
                end else begin
                    // Issue the first read on the way into DUMP_RD so it is
                    // on the bus during that state.
                    cpu_en_d    = 1'b0;
                    k_clr       = 1'b1;
                    dmem_ren_d  = 1'b1;
                    dmem_addr_d = '0;
                    state_d     = S_DUMP_RD;
                end
            end

            S_DUMP_RD: begin
                if (dmem_ren_q) begin
                    dmem_ren_d = 1'b0;
                    state_d    = S_DUMP_WT;
                end else begin
                    // Arrived straight from LOAD_D: the last write occupies
                    // the port this cycle, so the read goes out next cycle.
                    dmem_ren_d  = 1'b1;
                    dmem_addr_d = k_addr;
                end
            end

            S_DUMP_WT: begin
                out_data_d  = bus.dmem_rdata;
                out_valid_d = 1'b1;
                state_d     = S_DUMP_OUT;
            end

            S_DUMP_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (k_is_last) begin
                        k_clr   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        k_inc       = 1'b1;
                        dmem_ren_d  = 1'b1;
                        dmem_addr_d = k_next_addr;
                        state_d     = S_DUMP_RD;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            run_cnt_q    <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            imem_addr_q  <= '0;
            imem_wen_q   <= 1'b0;
            imem_wdata_q <= '0;
            dmem_addr_q  <= '0;
            dmem_wen_q   <= 1'b0;
            dmem_ren_q   <= 1'b0;
            dmem_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            imem_addr_q  <= imem_addr_d;
            imem_wen_q   <= imem_wen_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_ren_q   <= dmem_ren_d;
            dmem_wdata_q <= dmem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cpu_en_q     <= cpu_en_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign cpu_enable     = cpu_en_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wen   = imem_wen_q;
    assign bus.imem_ren   = 1'b0;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wen   = dmem_wen_q;
    assign bus.dmem_ren   = dmem_ren_q;
    assign bus.dmem_wdata = dmem_wdata_q;

endmodule
